// File: rtl/dlfloat_mac_host.sv
// dlfloat_mac_host: feeds operand pairs to the two-phase DLFloat MAC tile and reassembles its byte-serial results.
module dlfloat_mac_host #(
  parameter int FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        acc_clr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  output logic [15:0] mac_data,
  input  logic [7:0]  mac_byte,
  output logic        mac_rst_n,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_data,
  output logic        overrun,
  output logic [15:0] pair_count
);
  localparam int AW = $clog2(FIFO_DEPTH);
  typedef enum logic {CLR, RUN} state_t;
  state_t r_state, w_next;
  logic          r_clr_cnt, r_p, r_low_held;
  logic [7:0]    r_low;
  logic [15:0]   r_stage;
  logic [31:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr, r_rd;
  logic [AW:0]   r_cnt;
  logic          w_run, w_push, w_pop, w_load, w_empty;
  logic [31:0]   w_head;
  assign w_empty  = r_cnt == '0;
  assign in_ready = r_cnt != (AW+1)'(FIFO_DEPTH);
  assign w_run    = r_state == RUN && !acc_clr;
  assign w_push   = in_valid && in_ready;
  assign w_pop    = w_run && r_p && !w_empty;
  assign w_load   = w_run && !r_p && r_low_held;
  assign w_head   = r_mem[r_rd];
  always_comb begin
    w_next = r_state;
    if (r_state == CLR) w_next = r_clr_cnt ? RUN : CLR;
    else if (acc_clr) w_next = CLR;
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) r_state <= CLR;
    else r_state <= w_next;
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wr] <= {in_a, in_b};
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr       <= '0;
      r_rd       <= '0;
      r_cnt      <= '0;
      r_clr_cnt  <= 1'b0;
      r_p        <= 1'b0;
      r_low_held <= 1'b0;
      r_low      <= '0;
      r_stage    <= '0;
      mac_data   <= '0;
      mac_rst_n  <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      overrun    <= 1'b0;
      pair_count <= '0;
    end else begin
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
      r_cnt      <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      r_clr_cnt  <= r_state == CLR && !r_clr_cnt;
      r_p        <= w_run && !r_p;
      r_low_held <= w_run && r_p;
      mac_rst_n  <= w_next == RUN;
      // A goes out on the p==1 edge so it sits on the bus for the whole p==0 cycle
      mac_data   <= !w_run ? 16'h0 : !r_p ? r_stage : w_empty ? 16'h0 : w_head[31:16];
      r_stage    <= !w_run ? 16'h0 : !r_p ? r_stage : w_empty ? 16'h0 : w_head[15:0];
      pair_count <= pair_count + 16'(w_pop);
      if (w_run && r_p) r_low <= mac_byte;
      if (w_load) out_data <= {mac_byte, r_low};
      out_valid  <= w_load || (out_valid && !out_ready);
      overrun    <= overrun || (w_load && out_valid && !out_ready);
    end
  end
endmodule

// File: tb/tb_dlfloat_mac_host.sv
// tb_dlfloat_mac_host: table vectors, corner sequences and random traffic against a queue-based model.
module tb_dlfloat_mac_host;
  localparam int D = 2;
  logic        clk = 0, rst = 1, acc_clr = 0, in_valid = 0, out_ready = 1;
  logic [15:0] in_a = 0, in_b = 0;
  logic [7:0]  mac_byte = 0;
  logic        in_ready, mac_rst_n, out_valid, overrun;
  logic [15:0] mac_data, out_data, pair_count;
  int tests = 0, fails = 0;
  logic [31:0] pair_q[$];
  bit          m_run, m_clr, m_ph, m_lowheld, m_ov, m_ovr, m_rstn;
  logic [15:0] m_stage, m_data, m_od, m_pc;
  logic [7:0]  m_low;
  typedef struct {
    logic [15:0] a, b;
    logic [7:0]  lo, hi;
    logic [15:0] res;
  } vec_t;
  vec_t vt[4];

  dlfloat_mac_host #(.FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .acc_clr(acc_clr), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .mac_data(mac_data), .mac_byte(mac_byte), .mac_rst_n(mac_rst_n),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .overrun(overrun),
    .pair_count(pair_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", n, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    pair_q.delete();
    m_run = 0; m_clr = 0; m_ph = 0; m_lowheld = 0; m_ov = 0; m_ovr = 0; m_rstn = 0;
    m_stage = 0; m_data = 0; m_od = 0; m_pc = 0; m_low = 0;
  endtask

  task automatic model_step(input bit ac, input bit iv, input logic [15:0] a, input logic [15:0] b,
                            input bit ordy, input logic [7:0] mb);
    bit push, load;
    logic [31:0] h;
    push = iv && pair_q.size() < D;
    load = 0;
    if (!m_run) begin
      m_data = 0; m_stage = 0; m_lowheld = 0;
      if (m_clr) begin m_run = 1; m_ph = 0; m_rstn = 1; m_clr = 0; end
      else m_clr = 1;
    end else if (ac) begin
      m_run = 0; m_clr = 0; m_rstn = 0; m_data = 0; m_stage = 0; m_lowheld = 0; m_ph = 0;
    end else if (m_ph) begin
      if (pair_q.size() > 0) begin
        h = pair_q.pop_front();
        m_data = h[31:16]; m_stage = h[15:0]; m_pc = m_pc + 1;
      end else begin
        m_data = 0; m_stage = 0;
      end
      m_low = mb; m_lowheld = 1; m_ph = 0;
    end else begin
      m_data = m_stage;
      load = m_lowheld;
      m_lowheld = 0; m_ph = 1;
    end
    if (load) begin
      if (m_ov && !ordy) m_ovr = 1;
      m_od = {mb, m_low};
      m_ov = 1;
    end else if (ordy) m_ov = 0;
    if (push) pair_q.push_back({a, b});
  endtask

  task automatic check_all();
    chk("mac_data", mac_data, m_data);
    chk("mac_rst_n", mac_rst_n, m_rstn);
    chk("in_ready", in_ready, pair_q.size() < D);
    chk("out_valid", out_valid, m_ov);
    chk("out_data", out_data, m_od);
    chk("overrun", overrun, m_ovr);
    chk("pair_count", pair_count, m_pc);
  endtask

  task automatic cyc();
    bit ac, iv, ordy, r;
    logic [15:0] a, b;
    logic [7:0] mb;
    ac = acc_clr; iv = in_valid; ordy = out_ready; a = in_a; b = in_b; mb = mac_byte; r = rst;
    @(posedge clk);
    if (r) model_reset();
    else model_step(ac, iv, a, b, ordy, mb);
    #1;
    check_all();
  endtask

  task automatic wait_pop();
    logic [15:0] p0;
    p0 = pair_count;
    for (int k = 0; k < 8; k++) begin
      cyc();
      if (pair_count != p0) return;
    end
    tests++; fails++;
    $display("FAIL pop_timeout: pair_count stuck at %h", pair_count);
  endtask

  task automatic push_pair(input logic [15:0] a, input logic [15:0] b);
    in_valid = 1; in_a = a; in_b = b;
    cyc();
    in_valid = 0;
  endtask

  initial begin
    vt[0] = '{16'h3E00, 16'h4000, 8'h34, 8'h12, 16'h1234};
    vt[1] = '{16'hBC00, 16'h7BFF, 8'hCD, 8'hAB, 16'hABCD};
    vt[2] = '{16'h0001, 16'hFFFF, 8'h00, 8'hFF, 16'hFF00};
    vt[3] = '{16'h7E00, 16'h0000, 8'h5A, 8'hA5, 16'hA55A};
    model_reset();
    cyc(); cyc();
    chk("reset_in_ready", in_ready, 1);
    chk("reset_rst_n", mac_rst_n, 0);
    rst = 0;
    cyc(); chk("clr_edge1_rst_n", mac_rst_n, 0);
    cyc(); chk("clr_edge2_rst_n", mac_rst_n, 1);
    chk("first_bus", mac_data, 0);
    for (int i = 0; i < 4; i++) begin
      push_pair(vt[i].a, vt[i].b);
      wait_pop();
      chk("bus_a", mac_data, vt[i].a);
      cyc();
      chk("bus_b", mac_data, vt[i].b);
      mac_byte = vt[i].lo; cyc();
      mac_byte = vt[i].hi; cyc();
      chk("result", out_data, vt[i].res);
      chk("result_valid", out_valid, 1);
      chk("pairs", pair_count, 16'(i + 1));
    end
    chk("no_overrun_on_consume", overrun, 0);
    push_pair(16'h3E00, 16'h4000);
    push_pair(16'h1111, 16'h2222);
    wait_pop();
    chk("clr_mid_a", mac_data, 16'h3E00);
    acc_clr = 1; cyc(); acc_clr = 0;
    chk("clr_mid_rst_n", mac_rst_n, 0);
    chk("clr_mid_bus", mac_data, 0);
    chk("clr_mid_count", pair_count, 16'd5);
    wait_pop();
    chk("after_clr_a", mac_data, 16'h1111);
    chk("after_clr_count", pair_count, 16'd6);
    out_ready = 0;
    for (int i = 0; i < 6; i++) begin mac_byte = 8'(i * 37 + 5); cyc(); end
    chk("overrun_set", overrun, 1);
    out_ready = 1;
    cyc(); cyc();
    #3 rst = 1;
    #1 model_reset(); check_all();
    chk("async_rst_ready", in_ready, 1);
    cyc();
    rst = 0; acc_clr = 1;
    for (int i = 0; i <= D; i++) begin
      in_valid = 1; in_a = 16'hA000 + 16'(i); in_b = 16'hB000 + 16'(i);
      cyc();
    end
    chk("fifo_full", in_ready, 0);
    in_valid = 0;
    for (int i = 0; i < 4; i++) cyc();
    chk("held_no_pop", pair_count, 0);
    acc_clr = 0;
    for (int i = 0; i < D; i++) begin
      wait_pop();
      chk("drain_a", mac_data, 16'hA000 + 16'(i));
      cyc();
      chk("drain_b", mac_data, 16'hB000 + 16'(i));
    end
    for (int i = 0; i < 6; i++) cyc();
    chk("drain_total", pair_count, 16'(D));
    for (int i = 0; i < 400; i++) begin
      in_valid = 1'($urandom_range(0, 1));
      in_a = 16'($urandom); in_b = 16'($urandom);
      acc_clr = $urandom_range(0, 19) == 0;
      out_ready = $urandom_range(0, 3) != 0;
      mac_byte = 8'($urandom);
      cyc();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
